// File: rtl/cm82_pkg.sv
// Shared definitions for the digit-serial subtractor.
//   state_t   : controller states (IDLE, RUN, DONE)
//   DIGIT_W   : bits processed per RUN cycle
//   cnt_width : digit-counter width for a given digit count (never below 1)
package cm82_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 2;

    function automatic int cnt_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/cm82_digit_sub_add2_slice.sv
// Combinational 2-bit adder slice used by the subtractor once per RUN cycle.
//   a, b : 2-bit addends
//   cin  : carry in
//   s    : 2-bit sum
//   cout : carry out
module add2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);

    logic [2:0] sum_full;

    assign sum_full = {1'b0, a} + {1'b0, b} + {2'b00, cin};
    assign s        = sum_full[1:0];
    assign cout     = sum_full[2];

endmodule

// File: rtl/cm82_digit_sub.sv
// Digit-serial unsigned subtractor: diff = a - b - bin (mod 2^WIDTH),
// bout = 1 when a < b + bin. Subtraction is done as a + ~b + ~bin, two bits
// per cycle, least significant digit first.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, bin           : minuend, subtrahend, borrow-in (sampled at accept)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   diff, bout          : result; diff shows partial shift contents in RUN
module cm82_digit_sub
    import cm82_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int DIGITS = WIDTH / DIGIT_W;
    localparam int CNT_W  = cnt_width(DIGITS);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] nb_sh_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [1:0]       s_digit;
    logic             c_next;
    logic [WIDTH-1:0] diff_next;

    // One slice, fed from the low digit of the shift registers every cycle.
    add2_slice u_slice (
        .a    (a_sh_reg[1:0]),
        .b    (nb_sh_reg[1:0]),
        .cin  (carry_reg),
        .s    (s_digit),
        .cout (c_next)
    );

    // New digit enters at the MSB end so that after the last digit the
    // first-computed digit has reached bit 0.
    generate
        if (WIDTH > DIGIT_W) begin : g_diff_shift
            assign diff_next = {s_digit, diff_reg[WIDTH-1:DIGIT_W]};
        end else begin : g_diff_single
            assign diff_next = s_digit;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            nb_sh_reg <= '0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= a;
                        nb_sh_reg <= ~b;
                        // Inverted borrow acts as the +1 of two's complement
                        // when bin = 0.
                        carry_reg <= ~bin;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    diff_reg  <= diff_next;
                    a_sh_reg  <= a_sh_reg >> DIGIT_W;
                    nb_sh_reg <= nb_sh_reg >> DIGIT_W;
                    carry_reg <= c_next;
                    if (cnt_reg == LAST_DIGIT) begin
                        // No final carry means the subtraction wrapped.
                        bout_reg  <= ~c_next;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign diff      = diff_reg;
    assign bout      = bout_reg;

endmodule

// File: tb/tb_cm82_digit_sub.sv
// Self-checking bench for cm82_digit_sub (WIDTH = 16).
module tb_cm82_digit_sub;

    localparam int W      = 16;
    localparam int DIGITS = W / 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;

    int checks   = 0;
    int failures = 0;
    int results  = 0;
    int cyc      = 0;

    // Reference model: a busy flag, the number of edges since accept, and
    // the arithmetic result computed directly from the operands.
    logic         m_busy = 1'b0;
    int           m_edges = 0;
    logic [W-1:0] exp_diff = '0;
    logic         exp_bout = 1'b0;
    logic         b2b_mode = 1'b0;
    int           last_accept = -1;
    int           full_res;

    cm82_digit_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_edges <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                full_res = int'(a) - int'(b) - int'(bin);
                exp_diff <= full_res[W-1:0];
                exp_bout <= (full_res < 0);
                m_busy   <= 1'b1;
                m_edges  <= 0;
                if (b2b_mode && last_accept >= 0)
                    chk("b2b_spacing", 32'(cyc - last_accept), 32'd10);
                last_accept <= cyc;
            end
        end else if (m_edges < DIGITS) begin
            m_edges <= m_edges + 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("out_valid", 32'(out_valid), 32'(m_busy && m_edges == DIGITS));
            if (m_busy && m_edges == DIGITS) begin
                chk("diff", 32'(diff), 32'(exp_diff));
                chk("bout", 32'(bout), 32'(exp_bout));
                if (out_ready) results++;
            end
        end
    end

    // Directed operation with literal expectations; hold = cycles in DONE
    // with out_ready low before the result is taken.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic tbin,
                         input int hold, input logic [W-1:0] want_d, input logic want_b,
                         input string name);
        int k;
        int n;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_ready_before"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_in; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        // Accepting edge counts as edge 1.
        chk({name, "_latency_edges"}, 32'(n + 1), 32'(DIGITS + 1));
        chk({name, "_diff"}, 32'(diff), 32'(want_d));
        chk({name, "_bout"}, 32'(bout), 32'(want_b));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold_diff"}, 32'(diff), 32'(want_d));
            chk({name, "_hold_bout"}, 32'(bout), 32'(want_b));
            chk({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        chk({name, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;

        do_op(16'h0005, 16'h0003, 1'b0, 0, 16'h0002, 1'b0, "op_5m3");
        do_op(16'h0000, 16'h0001, 1'b0, 0, 16'hFFFF, 1'b1, "op_0m1");
        do_op(16'h8000, 16'h7FFF, 1'b1, 0, 16'h0000, 1'b0, "op_8000");
        do_op(16'h1234, 16'h1234, 1'b1, 5, 16'hFFFF, 1'b1, "op_hold");

        // Reset while digit 3 of an operation is being processed.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midrun_rst_diff", 32'(diff), 32'd0);
        chk("midrun_rst_bout", 32'(bout), 32'd0);
        #1;
        rst = 1'b0;
        do_op(16'h0010, 16'h0008, 1'b0, 0, 16'h0008, 1'b0, "op_after_rst");

        // Back-to-back random traffic; operands change every cycle so any
        // sampling outside the accepting edge shows up as a wrong result.
        @(negedge clk);
        b2b_mode = 1'b1;
        last_accept = -1;
        results = 0;
        guard = 0;
        out_ready = 1'b1;
        while (results < 100 && guard < 1500) begin
            a = W'($urandom);
            b = W'($urandom);
            bin = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("b2b_result_count", 32'(results >= 100), 32'd1);
        repeat (3) @(negedge clk);
        b2b_mode = 1'b0;
        out_ready = 1'b0;
        chk("final_in_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
